// File: rtl/ysyx_23060124_pipe_ctrl_if.sv
// Signal bundle between the core datapath and the pipeline sequencer.
// slave = sequencer side, master = datapath side.
interface ysyx_23060124_pipe_ctrl_if;
  // Valid/ready: a transfer happens in a cycle where both are high. A producer
  // never waits for ready before raising valid, and holds its payload stable
  // until the transfer. exwb_valid is the EXU->WBU load enable; exwb_ready
  // says the WBU register can take it.
  logic        ifu_valid;
  logic        ifu_ready;
  logic [4:0]  idu_rs1_addr;
  logic [4:0]  idu_rs2_addr;
  logic        idu_rs1_used;
  logic        idu_rs2_used;
  logic [4:0]  idu_rd_addr;
  logic        idu_wen;
  logic        exu_done;
  logic        exwb_valid;
  logic        exwb_ready;
  logic        wb_brch;
  logic        wb_jal;
  logic        wb_jalr;
  logic        wb_mret;
  logic        wb_ecall;
  logic        wb_wen;
  logic [4:0]  wb_rd_addr;
  logic        id_valid;
  logic        ex_valid;
  logic        wb_valid;
  logic        flush;
  logic [1:0]  redirect_sel;
  logic [31:0] retire_cnt;
  logic [31:0] stall_cnt;
  logic        dbg_refill;
  logic [31:0] dbg_busy;

  modport slave (
    input  ifu_valid, idu_rs1_addr, idu_rs2_addr, idu_rs1_used, idu_rs2_used,
           idu_rd_addr, idu_wen, exu_done, wb_brch, wb_jal, wb_jalr, wb_mret,
           wb_ecall, wb_wen, wb_rd_addr,
    output ifu_ready, exwb_valid, exwb_ready, id_valid, ex_valid, wb_valid,
           flush, redirect_sel, retire_cnt, stall_cnt, dbg_refill, dbg_busy
  );

  modport master (
    output ifu_valid, idu_rs1_addr, idu_rs2_addr, idu_rs1_used, idu_rs2_used,
           idu_rd_addr, idu_wen, exu_done, wb_brch, wb_jal, wb_jalr, wb_mret,
           wb_ecall, wb_wen, wb_rd_addr,
    input  ifu_ready, exwb_valid, exwb_ready, id_valid, ex_valid, wb_valid,
           flush, redirect_sel, retire_cnt, stall_cnt, dbg_refill, dbg_busy
  );
endinterface

// File: rtl/ysyx_23060124_pipe_ctrl.sv
// In-order IF/ID/EX/WB sequencer: stage valids, RAW scoreboard, WB-stage
// redirect flush, retire and hazard-stall counters.
module ysyx_23060124_pipe_ctrl (
  input logic                       clock,
  input logic                       reset,
  ysyx_23060124_pipe_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN    = 1'b0,
    REFILL = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        id_valid_q, id_valid_d;
  logic        ex_valid_q, ex_valid_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        redirect;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        hazard;
  logic        ex_fire;
  logic        id_fire;
  logic        ifu_ready;
  logic        if_fire;
  logic [1:0]  redirect_sel;

  // Handshake and hazard terms; busy is the registered vector, no bypass.
  always_comb begin
    redirect = !reset && wb_valid_q &&
               (bus.wb_brch || bus.wb_jal || bus.wb_jalr || bus.wb_mret || bus.wb_ecall);
    rs1_busy = bus.idu_rs1_used && (bus.idu_rs1_addr != 5'd0) && busy_q[bus.idu_rs1_addr];
    rs2_busy = bus.idu_rs2_used && (bus.idu_rs2_addr != 5'd0) && busy_q[bus.idu_rs2_addr];
    hazard   = id_valid_q && (rs1_busy || rs2_busy);
    ex_fire  = ex_valid_q && bus.exu_done && !redirect;
    id_fire  = id_valid_q && !hazard && (!ex_valid_q || ex_fire) && !redirect;
    ifu_ready = (!id_valid_q || id_fire) && !redirect && !reset;
    if_fire  = bus.ifu_valid && ifu_ready;

    redirect_sel = 2'b00;
    if (redirect) begin
      if (bus.wb_ecall) begin
        redirect_sel = 2'b10;
      end else if (bus.wb_mret) begin
        redirect_sel = 2'b01;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wb_valid_d   = ex_fire;
    ex_valid_d   = id_fire || (ex_valid_q && !bus.exu_done);
    id_valid_d   = (if_fire && (state_q == RUN)) || (id_valid_q && !id_fire);
    busy_d       = busy_q;
    retire_cnt_d = retire_cnt_q + {31'd0, wb_valid_q};
    stall_cnt_d  = stall_cnt_q + {31'd0, (hazard && !redirect)};

    case (state_q)
      RUN:     if (redirect) state_d = REFILL;
      REFILL:  state_d = RUN;
      default: state_d = RUN;
    endcase

    // Clear before set so a same-cycle set of the same register wins.
    if (wb_valid_q && bus.wb_wen && (bus.wb_rd_addr != 5'd0)) begin
      busy_d[bus.wb_rd_addr] = 1'b0;
    end
    if (id_fire && bus.idu_wen && (bus.idu_rd_addr != 5'd0)) begin
      busy_d[bus.idu_rd_addr] = 1'b1;
    end

    // Every in-flight writer is the retiring instruction or younger than it.
    if (redirect) begin
      ex_valid_d = 1'b0;
      id_valid_d = 1'b0;
      busy_d     = 32'd0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      id_valid_q   <= 1'b0;
      ex_valid_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      busy_q       <= 32'd0;
      retire_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      id_valid_q   <= id_valid_d;
      ex_valid_q   <= ex_valid_d;
      wb_valid_q   <= wb_valid_d;
      busy_q       <= busy_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.ifu_ready    = ifu_ready;
  assign bus.exwb_valid   = ex_fire && !reset;
  assign bus.exwb_ready   = !reset;
  assign bus.id_valid     = id_valid_q;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.flush        = redirect;
  assign bus.redirect_sel = redirect_sel;
  assign bus.retire_cnt   = retire_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.dbg_refill   = (state_q == REFILL);
  assign bus.dbg_busy     = busy_q;

endmodule

// File: tb/tb_ysyx_23060124_pipe_ctrl.sv
// Bench for ysyx_23060124_pipe_ctrl: instruction-record pipeline model plus
// directed scenarios and a randomized run.
module tb_ysyx_23060124_pipe_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060124_pipe_ctrl_if bus();

  ysyx_23060124_pipe_ctrl dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] id;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic        wen;
    logic        brch;
    logic        jal;
    logic        jalr;
    logic        mret;
    logic        ecall;
  } ins_t;

  ins_t        m_id, m_ex, m_wb, f_ins;
  logic        m_refill;
  logic [31:0] m_busy, m_ret, m_stall;
  logic [31:0] next_id;
  logic [31:0] ret_log[$];
  logic [31:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  logic c_rst, c_ifu_valid, c_exu_done;

  logic        e_ifu_ready, e_exwb_valid, e_exwb_ready, e_id_v, e_ex_v, e_wb_v, e_flush, e_refill;
  logic [1:0]  e_sel;
  logic [31:0] e_ret, e_stall, e_busy;
  logic        a_ifu_ready, a_exwb_valid, a_exwb_ready, a_id_v, a_ex_v, a_wb_v, a_flush, a_refill;
  logic [1:0]  a_sel;
  logic [31:0] a_ret, a_stall, a_busy;

  function automatic ins_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic [4:0] rd, input logic wen,
                              input logic [4:0] cf);
    ins_t i;
    i = '0;
    i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2; i.rd = rd; i.wen = wen;
    {i.brch, i.jal, i.jalr, i.mret, i.ecall} = cf;
    return i;
  endfunction

  function automatic logic is_cf(input ins_t i);
    return i.brch | i.jal | i.jalr | i.mret | i.ecall;
  endfunction

  function automatic logic src_busy(input logic used, input logic [4:0] r, input logic [31:0] b);
    return used && (r != 5'd0) && b[r];
  endfunction

  // One clock of stimulus: drive at negedge, snapshot expected and actual,
  // then move the instruction records to where they sit after the posedge.
  task automatic cycle();
    ins_t nid, nex, nwb, fetched;
    logic flush, haz, ex_go, id_go, rdy, fire;
    logic [31:0] nb;
    @(negedge clk);
    rst = c_rst;
    bus.ifu_valid = c_ifu_valid;
    bus.exu_done  = c_exu_done;
    if (m_id.v) begin
      bus.idu_rs1_addr = m_id.rs1; bus.idu_rs1_used = m_id.u1;
      bus.idu_rs2_addr = m_id.rs2; bus.idu_rs2_used = m_id.u2;
      bus.idu_rd_addr  = m_id.rd;  bus.idu_wen      = m_id.wen;
    end else begin
      bus.idu_rs1_addr = 5'($urandom); bus.idu_rs1_used = 1'($urandom);
      bus.idu_rs2_addr = 5'($urandom); bus.idu_rs2_used = 1'($urandom);
      bus.idu_rd_addr  = 5'($urandom); bus.idu_wen      = 1'($urandom);
    end
    if (m_wb.v) begin
      {bus.wb_brch, bus.wb_jal, bus.wb_jalr, bus.wb_mret, bus.wb_ecall} =
        {m_wb.brch, m_wb.jal, m_wb.jalr, m_wb.mret, m_wb.ecall};
      bus.wb_wen = m_wb.wen; bus.wb_rd_addr = m_wb.rd;
    end else begin
      {bus.wb_brch, bus.wb_jal, bus.wb_jalr, bus.wb_mret, bus.wb_ecall} = 5'($urandom);
      bus.wb_wen = 1'($urandom); bus.wb_rd_addr = 5'($urandom);
    end
    #1;
    flush = !c_rst && m_wb.v && is_cf(m_wb);
    haz   = m_id.v && (src_busy(m_id.u1, m_id.rs1, m_busy) || src_busy(m_id.u2, m_id.rs2, m_busy));
    ex_go = m_ex.v && c_exu_done && !flush;
    id_go = m_id.v && !haz && (!m_ex.v || ex_go) && !flush;
    rdy   = (!m_id.v || id_go) && !flush && !c_rst;
    fire  = c_ifu_valid && rdy;

    e_ifu_ready = rdy;        e_exwb_valid = ex_go && !c_rst; e_exwb_ready = !c_rst;
    e_id_v = m_id.v;          e_ex_v = m_ex.v;               e_wb_v = m_wb.v;
    e_flush = flush;          e_refill = m_refill;
    e_sel = 2'b00;
    if (flush) e_sel = m_wb.ecall ? 2'b10 : (m_wb.mret ? 2'b01 : 2'b00);
    e_ret = m_ret; e_stall = m_stall; e_busy = m_busy;

    a_ifu_ready = bus.ifu_ready; a_exwb_valid = bus.exwb_valid; a_exwb_ready = bus.exwb_ready;
    a_id_v = bus.id_valid; a_ex_v = bus.ex_valid; a_wb_v = bus.wb_valid;
    a_flush = bus.flush; a_refill = bus.dbg_refill; a_sel = bus.redirect_sel;
    a_ret = bus.retire_cnt; a_stall = bus.stall_cnt; a_busy = bus.dbg_busy;

    if (c_rst) begin
      m_id = '0; m_ex = '0; m_wb = '0; m_refill = 1'b0;
      m_busy = '0; m_ret = '0; m_stall = '0;
    end else begin
      if (m_wb.v) begin
        ret_log.push_back(m_wb.id);
        m_ret = m_ret + 32'd1;
      end
      if (haz && !flush) m_stall = m_stall + 32'd1;
      nb = m_busy;
      if (m_wb.v && m_wb.wen && m_wb.rd != 5'd0) nb[m_wb.rd] = 1'b0;
      if (id_go && m_id.wen && m_id.rd != 5'd0) nb[m_id.rd] = 1'b1;
      if (flush) nb = '0;
      nwb = ex_go ? m_ex : '0;
      if (flush)                       nex = '0;
      else if (id_go)                  nex = m_id;
      else if (m_ex.v && !c_exu_done)  nex = m_ex;
      else                             nex = '0;
      fetched = f_ins; fetched.v = 1'b1; fetched.id = next_id;
      if (fire) next_id = next_id + 32'd1;
      if (flush)                    nid = '0;
      else if (fire && !m_refill)   nid = fetched;
      else if (m_id.v && !id_go)    nid = m_id;
      else                          nid = '0;
      m_id = nid; m_ex = nex; m_wb = nwb; m_busy = nb; m_refill = flush;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    c_rst = 1'b1; c_ifu_valid = 1'b0; c_exu_done = 1'b0;
    cycle();
    cycle();
    c_rst = 1'b0;
    ret_log.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    c_rst = 1'b1; c_ifu_valid = 1'b1; c_exu_done = 1'b1; f_ins = mk(0, 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 2; k++) begin
      cycle();
      n_vec++; if (a_ifu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ifu_ready got %0b want 0", a_ifu_ready); end
      n_vec++; if (a_exwb_ready !== 1'b0) begin n_err++; $display("FAIL reset_exwb_ready got %0b want 0", a_exwb_ready); end
      n_vec++; if (a_exwb_valid !== 1'b0) begin n_err++; $display("FAIL reset_exwb_valid got %0b want 0", a_exwb_valid); end
      n_vec++; if (a_flush !== 1'b0 || a_sel !== 2'b00) begin n_err++; $display("FAIL reset_flush got %0b/%0b want 0/00", a_flush, a_sel); end
    end
    c_rst = 1'b0; c_ifu_valid = 1'b0;
    cycle();
    n_vec++; if (a_ifu_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ifu_ready got %0b want 1", a_ifu_ready); end
    n_vec++; if ({a_id_v, a_ex_v, a_wb_v, a_refill} !== 4'b0000) begin n_err++; $display("FAIL post_reset_valids got %b want 0000", {a_id_v, a_ex_v, a_wb_v, a_refill}); end
    n_vec++; if (a_ret !== 32'd0 || a_stall !== 32'd0 || a_busy !== 32'd0) begin n_err++; $display("FAIL post_reset_state got ret=%0d stall=%0d busy=%h want 0", a_ret, a_stall, a_busy); end
  endtask

  task automatic test_stream();
    do_reset();
    c_exu_done = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      c_ifu_valid = (k < 8);
      f_ins = mk(0, 0, 0, 0, 5'(k + 1), 1, 0);
      cycle();
      if (k < 8) begin
        n_vec++; if (a_ifu_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready k=%0d got %0b want 1", k, a_ifu_ready); end
      end
      n_vec++; if (a_wb_v !== (k >= 3 && k <= 10)) begin n_err++; $display("FAIL stream_wb_valid k=%0d got %0b want %0b", k, a_wb_v, (k >= 3 && k <= 10)); end
    end
    n_vec++; if (a_ret !== 32'd8 || a_stall !== 32'd0) begin n_err++; $display("FAIL stream_counts got ret=%0d stall=%0d want 8/0", a_ret, a_stall); end
  endtask

  task automatic test_raw();
    do_reset();
    c_exu_done = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      c_ifu_valid = (k < 2);
      f_ins = (k == 0) ? mk(0, 0, 0, 0, 5, 1, 0) : mk(5, 1, 0, 0, 6, 1, 0);
      cycle();
      if (k == 2 || k == 3) begin
        n_vec++; if (a_busy[5] !== 1'b1) begin n_err++; $display("FAIL raw_busy5 k=%0d got %0b want 1", k, a_busy[5]); end
        n_vec++; if (a_id_v !== 1'b1 || a_ifu_ready !== 1'b0) begin n_err++; $display("FAIL raw_hold k=%0d got id=%0b rdy=%0b want 1/0", k, a_id_v, a_ifu_ready); end
      end
      if (k == 4) begin
        n_vec++; if (a_busy[5] !== 1'b0) begin n_err++; $display("FAIL raw_busy5_clear got %0b want 0", a_busy[5]); end
      end
      n_vec++; if (a_wb_v !== (k == 3 || k == 6)) begin n_err++; $display("FAIL raw_wb_valid k=%0d got %0b want %0b", k, a_wb_v, (k == 3 || k == 6)); end
    end
    n_vec++; if (a_stall !== 32'd2 || a_ret !== 32'd2) begin n_err++; $display("FAIL raw_counts got stall=%0d ret=%0d want 2/2", a_stall, a_ret); end
  endtask

  task automatic test_x0();
    do_reset();
    c_exu_done = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      c_ifu_valid = (k < 2);
      f_ins = (k == 0) ? mk(0, 0, 0, 0, 0, 1, 0) : mk(0, 1, 0, 1, 0, 1, 0);
      cycle();
      n_vec++; if (a_busy !== 32'd0) begin n_err++; $display("FAIL x0_busy k=%0d got %h want 0", k, a_busy); end
      n_vec++; if (a_wb_v !== (k == 3 || k == 4)) begin n_err++; $display("FAIL x0_wb_valid k=%0d got %0b want %0b", k, a_wb_v, (k == 3 || k == 4)); end
    end
    n_vec++; if (a_stall !== 32'd0 || a_ret !== 32'd2) begin n_err++; $display("FAIL x0_counts got stall=%0d ret=%0d want 0/2", a_stall, a_ret); end
  endtask

  task automatic test_redirect(input logic [4:0] cf, input logic [1:0] want_sel);
    do_reset();
    exp_q.delete();
    c_exu_done = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      c_ifu_valid = (k <= 5);
      case (k)
        0:       f_ins = mk(0, 0, 0, 0, 7, 1, cf);
        1:       f_ins = mk(0, 0, 0, 0, 1, 1, 0);
        2:       f_ins = mk(0, 0, 0, 0, 2, 1, 0);
        4:       f_ins = mk(0, 0, 0, 0, 3, 1, 0);
        default: f_ins = mk(0, 0, 0, 0, 4, 1, 0);
      endcase
      if (k == 0 || k == 5) exp_q.push_back(next_id);
      cycle();
      if (k == 2) begin
        n_vec++; if (a_flush !== 1'b0 || a_sel !== 2'b00) begin n_err++; $display("FAIL redir_early got %0b/%0b want 0/00", a_flush, a_sel); end
      end
      if (k == 3) begin
        n_vec++; if (a_flush !== 1'b1) begin n_err++; $display("FAIL redir_flush got %0b want 1", a_flush); end
        n_vec++; if (a_sel !== want_sel) begin n_err++; $display("FAIL redir_sel got %b want %b", a_sel, want_sel); end
        n_vec++; if (a_ifu_ready !== 1'b0) begin n_err++; $display("FAIL redir_ready got %0b want 0", a_ifu_ready); end
      end
      if (k == 4) begin
        n_vec++; if (a_refill !== 1'b1 || a_busy !== 32'd0) begin n_err++; $display("FAIL refill_state got refill=%0b busy=%h want 1/0", a_refill, a_busy); end
        n_vec++; if ({a_id_v, a_ex_v, a_wb_v, a_flush} !== 4'b0000) begin n_err++; $display("FAIL refill_valids got %b want 0000", {a_id_v, a_ex_v, a_wb_v, a_flush}); end
      end
      if (k == 5) begin
        n_vec++; if (a_refill !== 1'b0 || a_id_v !== 1'b0) begin n_err++; $display("FAIL refill_drop got refill=%0b id=%0b want 0/0", a_refill, a_id_v); end
      end
      if (k >= 4 && k <= 8) begin
        n_vec++; if (a_wb_v !== (k == 8)) begin n_err++; $display("FAIL redir_wb_valid k=%0d got %0b want %0b", k, a_wb_v, (k == 8)); end
      end
    end
    n_vec++; if (a_ret !== 32'd2) begin n_err++; $display("FAIL redir_retire got %0d want 2", a_ret); end
    n_vec++; if (ret_log.size() != exp_q.size() || ret_log[0] !== exp_q[0] || ret_log[1] !== exp_q[1]) begin
      n_err++; $display("FAIL redir_order got %0d retires want %0d", ret_log.size(), exp_q.size());
    end
  endtask

  task automatic test_multicycle();
    for (int k = 0; k <= 6; k++) begin
      c_ifu_valid = (k < 2);
      c_exu_done = !(k >= 2 && k <= 5);
      c_rst = (k == 5);
      f_ins = (k == 0) ? mk(0, 0, 0, 0, 1, 1, 0) : mk(0, 0, 0, 0, 2, 1, 0);
      cycle();
      if (k >= 2 && k <= 5) begin
        n_vec++; if (a_exwb_valid !== 1'b0 || a_wb_v !== 1'b0) begin n_err++; $display("FAIL mc_wb k=%0d got exwb=%0b wb=%0b want 0/0", k, a_exwb_valid, a_wb_v); end
        n_vec++; if (a_id_v !== 1'b1 || a_ex_v !== 1'b1) begin n_err++; $display("FAIL mc_hold k=%0d got id=%0b ex=%0b want 1/1", k, a_id_v, a_ex_v); end
      end
      if (k == 4) begin
        n_vec++; if (a_ret !== e_ret) begin n_err++; $display("FAIL mc_retire got %0d want %0d", a_ret, e_ret); end
      end
      if (k == 5) begin
        n_vec++; if (a_exwb_ready !== 1'b0 || a_ifu_ready !== 1'b0) begin n_err++; $display("FAIL mc_reset_ready got %0b/%0b want 0/0", a_exwb_ready, a_ifu_ready); end
      end
      if (k == 6) begin
        n_vec++; if ({a_id_v, a_ex_v, a_wb_v} !== 3'b000) begin n_err++; $display("FAIL mc_reset_valids got %b want 000", {a_id_v, a_ex_v, a_wb_v}); end
        n_vec++; if (a_ret !== 32'd0 || a_stall !== 32'd0) begin n_err++; $display("FAIL mc_reset_counts got %0d/%0d want 0/0", a_ret, a_stall); end
      end
    end
    c_rst = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0] cf;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      c_rst       = ($urandom_range(0, 199) == 0);
      c_ifu_valid = ($urandom_range(0, 3) != 0);
      c_exu_done  = ($urandom_range(0, 9) < 7);
      cf = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      f_ins = mk(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), cf);
      cycle();
      n_vec++; if (a_ifu_ready !== e_ifu_ready) begin n_err++; $display("FAIL rnd_ifu_ready n=%0d got %0b want %0b", n, a_ifu_ready, e_ifu_ready); end
      n_vec++; if (a_exwb_valid !== e_exwb_valid) begin n_err++; $display("FAIL rnd_exwb_valid n=%0d got %0b want %0b", n, a_exwb_valid, e_exwb_valid); end
      n_vec++; if (a_exwb_ready !== e_exwb_ready) begin n_err++; $display("FAIL rnd_exwb_ready n=%0d got %0b want %0b", n, a_exwb_ready, e_exwb_ready); end
      n_vec++; if (a_id_v !== e_id_v) begin n_err++; $display("FAIL rnd_id_valid n=%0d got %0b want %0b", n, a_id_v, e_id_v); end
      n_vec++; if (a_ex_v !== e_ex_v) begin n_err++; $display("FAIL rnd_ex_valid n=%0d got %0b want %0b", n, a_ex_v, e_ex_v); end
      n_vec++; if (a_wb_v !== e_wb_v) begin n_err++; $display("FAIL rnd_wb_valid n=%0d got %0b want %0b", n, a_wb_v, e_wb_v); end
      n_vec++; if (a_flush !== e_flush) begin n_err++; $display("FAIL rnd_flush n=%0d got %0b want %0b", n, a_flush, e_flush); end
      n_vec++; if (a_sel !== e_sel) begin n_err++; $display("FAIL rnd_sel n=%0d got %b want %b", n, a_sel, e_sel); end
      n_vec++; if (a_refill !== e_refill) begin n_err++; $display("FAIL rnd_refill n=%0d got %0b want %0b", n, a_refill, e_refill); end
      n_vec++; if (a_ret !== e_ret) begin n_err++; $display("FAIL rnd_retire n=%0d got %0d want %0d", n, a_ret, e_ret); end
      n_vec++; if (a_stall !== e_stall) begin n_err++; $display("FAIL rnd_stall n=%0d got %0d want %0d", n, a_stall, e_stall); end
      n_vec++; if (a_busy !== e_busy) begin n_err++; $display("FAIL rnd_busy n=%0d got %h want %h", n, a_busy, e_busy); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m_id = '0; m_ex = '0; m_wb = '0; f_ins = '0;
    m_refill = 1'b0; m_busy = '0; m_ret = '0; m_stall = '0; next_id = '0;
    c_rst = 1'b1; c_ifu_valid = 1'b0; c_exu_done = 1'b0;
    bus.ifu_valid = 1'b0; bus.exu_done = 1'b0;
    bus.idu_rs1_addr = '0; bus.idu_rs2_addr = '0; bus.idu_rs1_used = 1'b0; bus.idu_rs2_used = 1'b0;
    bus.idu_rd_addr = '0; bus.idu_wen = 1'b0;
    bus.wb_brch = 1'b0; bus.wb_jal = 1'b0; bus.wb_jalr = 1'b0; bus.wb_mret = 1'b0; bus.wb_ecall = 1'b0;
    bus.wb_wen = 1'b0; bus.wb_rd_addr = '0;

    test_reset();
    test_stream();
    test_raw();
    test_x0();
    test_redirect(5'b10000, 2'b00);
    test_redirect(5'b00011, 2'b10);
    test_redirect(5'b00010, 2'b01);
    test_multicycle();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
